mips_multicycle_control: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath. Decodes opcode, steps each instruction

---
 rtl/mips_multicycle_control.sv | 213 +++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Main control FSM for the multicycle MIPS datapath. Steps each instruction
//   through fetch/decode/execute/memory/writeback and drives the datapath
//   mux selects, write enables and ALUOp.
//
//   Ports
//     clk, rst_n       clock (rising edge), asynchronous active-low reset
//     opcode[5:0]      IR[31:26], valid from DECODE onward
//     mem_ready        memory completes the current read/write this cycle
//     PCWrite .. PCSource   datapath control lines (Moore outputs, with
//                      mem_ready gating on the write enables of wait states)
//     instr_done       one-cycle pulse in the last state of a retired instruction
//     illegal_op       one-cycle pulse in DECODE on an unknown opcode
//     state[3:0]       current state encoding (debug)
//
//   state  | meaning
//   -------+-----------------------------------------------
//   RST    | held in reset / first cycle after release
//   FETCH  | read instruction at PC, PC <= PC + 4
//   DECODE | read registers, precompute branch target
//   MEMADR | effective address for lw/sw
//   MEMRD  | data memory read (waits on mem_ready)
//   MEMWB  | write MDR to rt
//   MEMWR  | data memory write (waits on mem_ready)
//   EXEC   | R-type ALU operation
//   ALUWB  | write ALUOut to rd
//   BRANCH | beq compare and conditional PC load
//   JUMP   | PC <= jump target
//   IEXEC  | I-type ALU operation
//   IWB    | write ALUOut to rt
//   HALT   | parked after an illegal opcode until reset
module mips_multicycle_control #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_RST;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_RST:    nxt_state = S_FETCH;
      S_FETCH:  nxt_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                          nxt_state = S_EXEC;
          OP_LW, OP_SW:                      nxt_state = S_MEMADR;
          OP_BEQ:                            nxt_state = S_BRANCH;
          OP_J:                              nxt_state = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt_state = S_IEXEC;
          default:                           nxt_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt_state = S_FETCH;
      S_MEMWR:  nxt_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt_state = S_ALUWB;
      S_ALUWB:  nxt_state = S_FETCH;
      S_BRANCH: nxt_state = S_FETCH;
      S_JUMP:   nxt_state = S_FETCH;
      S_IEXEC:  nxt_state = S_IWB;
      S_IWB:    nxt_state = S_FETCH;
      S_HALT:   nxt_state = S_HALT;
      default:  nxt_state = S_FETCH;   // 14/15 recover to fetch
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (cur_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR and PC only load on the cycle the read actually completes
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: illegal_op = 1'b0;
          default:                           illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (opcode)
          OP_ANDI: ALUOp = 3'b011;
          OP_ORI:  ALUOp = 3'b100;
          OP_SLTI: ALUOp = 3'b101;
          default: ALUOp = 3'b000;
        endcase
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, srca_a;
  logic [1:0] srcb_a, pcs_a;
  logic [2:0] aluop_a;
  logic       done_a, ill_a;
  logic [3:0] st_a;

  logic       pcw_h, pcwc_h, iord_h, mrd_h, mwr_h, irw_h, m2r_h, rdst_h, rw_h, srca_h;
  logic [1:0] srcb_h, pcs_h;
  logic [2:0] aluop_h;
  logic       done_h, ill_h;
  logic [3:0] st_h;

  always #5 clk = ~clk;

  mips_multicycle_control #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .IorD(iord_a), .MemRead(mrd_a),
    .MemWrite(mwr_a), .IRWrite(irw_a), .MemtoReg(m2r_a), .RegDst(rdst_a),
    .RegWrite(rw_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a), .ALUOp(aluop_a),
    .PCSource(pcs_a), .instr_done(done_a), .illegal_op(ill_a), .state(st_a)
  );

  mips_multicycle_control #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw_h), .PCWriteCond(pcwc_h), .IorD(iord_h), .MemRead(mrd_h),
    .MemWrite(mwr_h), .IRWrite(irw_h), .MemtoReg(m2r_h), .RegDst(rdst_h),
    .RegWrite(rw_h), .ALUSrcA(srca_h), .ALUSrcB(srcb_h), .ALUOp(aluop_h),
    .PCSource(pcs_h), .instr_done(done_h), .illegal_op(ill_h), .state(st_h)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
  //  ALUSrcA,ALUSrcB,ALUOp,PCSource,instr_done,illegal_op}
  wire [18:0] ctrl_a = {pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a,
                        srca_a, srcb_a, aluop_a, pcs_a, done_a, ill_a};
  wire [18:0] ctrl_h = {pcw_h, pcwc_h, iord_h, mrd_h, mwr_h, irw_h, m2r_h, rdst_h, rw_h,
                        srca_h, srcb_h, aluop_h, pcs_h, done_h, ill_h};

  localparam int RST = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5,
                 MEMWR = 6, EXEC = 7, ALUWB = 8, BRANCH = 9, JUMP = 10, IEXEC = 11,
                 IWB = 12, HALT = 13;

  int checks   = 0;
  int failures = 0;
  bit halted_h = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // instruction kind: 0 R, 1 lw, 2 sw, 3 beq, 4 j, 5 I-ALU, -1 illegal
  function automatic int op_kind(input logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b000010: return 4;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return 5;
      default:   return -1;
    endcase
  endfunction

  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      6'b001100: return 3'b011;
      6'b001101: return 3'b100;
      6'b001010: return 3'b101;
      default:   return 3'b000;
    endcase
  endfunction

  // Expected control word for a state, built field by field from the datapath roles.
  function automatic logic [18:0] exp_ctrl(input int st, input logic [5:0] op, input bit rdy);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0;
    logic srca = 0, done = 0, ill = 0;
    logic [1:0] srcb = 0, pcs = 0;
    logic [2:0] aop = 0;
    case (st)
      FETCH:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      DECODE: begin srcb = 2'b11; ill = (op_kind(op) < 0); end
      MEMADR: begin srca = 1; srcb = 2'b10; end
      MEMRD:  begin mrd = 1; iord = 1; end
      MEMWB:  begin rw = 1; m2r = 1; done = 1; end
      MEMWR:  begin mwr = 1; iord = 1; done = rdy; end
      EXEC:   begin srca = 1; aop = 3'b010; end
      ALUWB:  begin rw = 1; rdst = 1; done = 1; end
      BRANCH: begin srca = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; done = 1; end
      JUMP:   begin pcw = 1; pcs = 2'b10; done = 1; end
      IEXEC:  begin srca = 1; srcb = 2'b10; aop = imm_aluop(op); end
      IWB:    begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, done, ill};
  endfunction

  // One clock cycle: drive inputs, check both instances, advance to just after the edge.
  task automatic step(input int exp_st, input bit rdy, input logic [5:0] op, inout int done_cnt);
    mem_ready = rdy;
    opcode    = op;
    #1;
    chk("state", 32'(st_a), 32'(exp_st));
    chk("ctrl", 32'(ctrl_a), 32'(exp_ctrl(exp_st, op, rdy)));
    chk("rd_wr_excl", 32'(mrd_a & mwr_a), 32'd0);
    if (halted_h) begin
      chk("halt_state", 32'(st_h), HALT);
      chk("halt_ctrl", 32'(ctrl_h), 32'd0);
    end else begin
      chk("h_state", 32'(st_h), 32'(exp_st));
      chk("h_ctrl", 32'(ctrl_h), 32'(exp_ctrl(exp_st, op, rdy)));
    end
    done_cnt += int'(done_a);
    @(posedge clk);
    #1;
    if (exp_st == DECODE && op_kind(op) < 0) halted_h = 1'b1;
  endtask

  // A wait state: fw cycles of mem_ready=0 then one cycle of mem_ready=1.
  task automatic wait_step(input int st, input int nwait, input logic [5:0] op, inout int dc);
    for (int i = 0; i < nwait; i++) step(st, 1'b0, op, dc);
    step(st, 1'b1, op, dc);
  endtask

  // Runs one instruction starting in FETCH; the path comes from the instruction kind.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    int dc = 0;
    int k  = op_kind(op);
    wait_step(FETCH, fw, op, dc);
    step(DECODE, 1'($urandom), op, dc);
    case (k)
      0: begin step(EXEC, 1'($urandom), op, dc); step(ALUWB, 1'($urandom), op, dc); end
      1: begin
        step(MEMADR, 1'($urandom), op, dc);
        wait_step(MEMRD, mw, op, dc);
        step(MEMWB, 1'($urandom), op, dc);
      end
      2: begin step(MEMADR, 1'($urandom), op, dc); wait_step(MEMWR, mw, op, dc); end
      3: step(BRANCH, 1'($urandom), op, dc);
      4: step(JUMP, 1'($urandom), op, dc);
      5: begin step(IEXEC, 1'($urandom), op, dc); step(IWB, 1'($urandom), op, dc); end
      default: ;
    endcase
    chk("done_pulses", 32'(dc), (k < 0) ? 32'd0 : 32'd1);
  endtask

  task automatic reset_check_release();
    #1;
    chk("rst_state", 32'(st_a), RST);
    chk("rst_ctrl", 32'(ctrl_a), 32'd0);
    chk("rst_h_state", 32'(st_h), RST);
    chk("rst_h_ctrl", 32'(ctrl_h), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold", 32'(st_a), RST);
    rst_n = 1'b1;
    halted_h = 1'b0;
    #1;
    chk("rel_state", 32'(st_a), RST);
    @(posedge clk);
    #1;
    chk("rel_fetch", 32'(st_a), FETCH);
    chk("rel_h_fetch", 32'(st_h), FETCH);
  endtask

  localparam logic [5:0] LEGAL [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                       6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};

  initial begin
    int dc;
    logic [5:0] op;
    rst_n = 1'b0;
    opcode = 6'd0;
    mem_ready = 1'b0;
    #2;
    reset_check_release();

    run_instr(6'b000000, 0, 0);   // R-type, no waits
    run_instr(6'b100011, 2, 3);   // lw with fetch and memory waits
    run_instr(6'b000100, 0, 0);   // beq
    run_instr(6'b001101, 0, 0);   // ori
    run_instr(6'b001010, 1, 0);   // slti
    run_instr(6'b101011, 0, 2);   // sw
    run_instr(6'b000010, 0, 0);   // j
    run_instr(6'b111111, 0, 0);   // illegal: dut refetches, dut_h halts
    run_instr(6'b001100, 0, 0);   // andi with dut_h parked
    run_instr(6'b001000, 0, 0);   // addi

    // sw aborted by reset while waiting in MEMWR
    dc = 0;
    step(FETCH, 1'b1, 6'b101011, dc);
    step(DECODE, 1'b1, 6'b101011, dc);
    step(MEMADR, 1'b1, 6'b101011, dc);
    mem_ready = 1'b0;
    #1;
    chk("sw_wait_state", 32'(st_a), MEMWR);
    chk("sw_wait_mwr", 32'(mwr_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", 32'(st_a), RST);
    chk("abort_mwr", 32'(mwr_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    reset_check_release();

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        do op = 6'($urandom); while (op_kind(op) >= 0);
      end else begin
        op = LEGAL[$urandom_range(0, 8)];
      end
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
